// File: rtl/fiat_25519_pkg.sv
// rtl/fiat_25519_pkg.sv - shared constants, FSM state and limb storage types for the 25519 carry chain
package fiat_25519_pkg;

    localparam int NUM_LIMBS   = 10;
    localparam int LIMB_W_EVEN = 26;
    localparam int LIMB_W_ODD  = 25;
    localparam int FOLD_K      = 19;
    localparam int COL_W       = 64;
    localparam int CARRY_W     = 39;
    localparam int FOLD_W      = 45;
    localparam int OUT_W       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FOLD  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    typedef logic [OUT_W-1:0] limb_arr_t [NUM_LIMBS];

endpackage

// File: rtl/fiat_25519_carry_square_carry_chain_if.sv
// rtl/fiat_25519_carry_square_carry_chain_if.sv - column-in / limb-out stream bundle
interface fiat_25519_carry_square_carry_chain_if;

    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    // Producer of columns and consumer of limbs
    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

    // The carry chain itself
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

endinterface

// File: rtl/fiat_25519_carry_step.sv
// rtl/fiat_25519_carry_step.sv - one limb of the chain: add carry, mask to W bits, shift out new carry (FIAT_25519_CARRY_CHAIN_ERR_EN adds o_ovf)
module fiat_25519_carry_step
    import fiat_25519_pkg::*;
#(
    parameter int W = LIMB_W_EVEN
) (
    input  logic [COL_W-1:0]   i_data,
    input  logic [CARRY_W-1:0] i_carry,
    output logic [W-1:0]       o_limb,
    output logic [CARRY_W-1:0] o_carry
`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
    ,
    output logic               o_ovf
`endif
);

    logic [COL_W-1:0] w_t;

    // The sum wraps at 64 bits; the dropped bit only matters as an overflow flag
`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
    assign {o_ovf, w_t} = {1'b0, i_data} + {{(COL_W-CARRY_W+1){1'b0}}, i_carry};
`else
    assign w_t = i_data + {{(COL_W-CARRY_W){1'b0}}, i_carry};
`endif

    assign o_limb  = w_t[W-1:0];
    assign o_carry = CARRY_W'(w_t >> W);

endmodule

// File: rtl/fiat_25519_carry_square_carry_chain.sv
// rtl/fiat_25519_carry_square_carry_chain.sv - 10-column carry chain with mod 2^255-19 fold; FIAT_25519_CARRY_CHAIN_ERR_EN adds sticky err
module fiat_25519_carry_square_carry_chain
    import fiat_25519_pkg::*;
#(
    parameter int ID = 1
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    fiat_25519_carry_square_carry_chain_if.slave bus
`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
    ,
    output logic err
`endif
);

    // ID is an instance tag only
    if (ID >= 0) begin : g_inst_tag
    end

    state_t              r_state;
    logic [CARRY_W-1:0]  r_c;
    logic [3:0]          r_in_idx;
    logic [3:0]          r_out_idx;
    limb_arr_t           r_limbs;

    logic                      w_s_hs;
    logic [3:0]                w_idx;
    logic [CARRY_W-1:0]        w_c_in;
    logic [LIMB_W_EVEN-1:0]    w_limb_even;
    logic [LIMB_W_ODD-1:0]     w_limb_odd;
    logic [CARRY_W-1:0]        w_c_even;
    logic [CARRY_W-1:0]        w_c_odd;
    logic [OUT_W-1:0]          w_limb;
    logic [CARRY_W-1:0]        w_c_next;
    logic [FOLD_W-1:0]         w_u;
    logic [3:0]                w_out_next;

    assign w_s_hs     = bus.s_valid & bus.s_ready;
    // A word accepted in IDLE starts a new frame, so it sees index 0 and no carry
    assign w_idx      = (r_state == IDLE) ? 4'd0 : r_in_idx;
    assign w_c_in     = (r_state == IDLE) ? '0 : r_c;
    assign w_out_next = r_out_idx + 4'd1;

`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
    logic w_ovf_even;
    logic w_ovf_odd;
    logic w_ovf;
`endif

    fiat_25519_carry_step #(
        .W (LIMB_W_EVEN)
    ) u_step_even (
        .i_data  (bus.s_data),
        .i_carry (w_c_in),
        .o_limb  (w_limb_even),
        .o_carry (w_c_even)
`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
        ,
        .o_ovf   (w_ovf_even)
`endif
    );

    fiat_25519_carry_step #(
        .W (LIMB_W_ODD)
    ) u_step_odd (
        .i_data  (bus.s_data),
        .i_carry (w_c_in),
        .o_limb  (w_limb_odd),
        .o_carry (w_c_odd)
`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
        ,
        .o_ovf   (w_ovf_odd)
`endif
    );

    // Odd columns use the 25-bit step, even columns the 26-bit one
    assign w_limb   = w_idx[0] ? OUT_W'(w_limb_odd) : OUT_W'(w_limb_even);
    assign w_c_next = w_idx[0] ? w_c_odd : w_c_even;

`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
    assign w_ovf = w_idx[0] ? w_ovf_odd : w_ovf_even;
`endif

    // Carry out of limb 9 weighs 2^255 = 19 mod p, so it folds back into limb 0
    assign w_u = FOLD_W'(r_limbs[0]) + FOLD_W'(r_c) * FOLD_W'(FOLD_K);

    // Frame FSM: accumulate 10 columns, fold the top carry, then stream 10 limbs
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= IDLE;
            r_c         <= '0;
            r_in_idx    <= '0;
            r_out_idx   <= '0;
            r_limbs     <= '{default: '0};
            bus.s_ready <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    bus.s_ready <= 1'b1;
                    r_c         <= '0;
                    r_in_idx    <= '0;
                    if (w_s_hs) begin
                        r_limbs[0] <= w_limb;
                        r_c        <= w_c_next;
                        r_in_idx   <= 4'd1;
                        r_state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_s_hs) begin
                        r_limbs[w_idx] <= w_limb;
                        r_c            <= w_c_next;
                        if (r_in_idx == 4'(NUM_LIMBS - 1)) begin
                            r_in_idx    <= '0;
                            bus.s_ready <= 1'b0;
                            r_state     <= FOLD;
                        end else begin
                            r_in_idx <= r_in_idx + 4'd1;
                        end
                    end
                end
                FOLD: begin
                    r_limbs[0] <= OUT_W'(w_u[LIMB_W_EVEN-1:0]);
                    r_limbs[1] <= r_limbs[1] + OUT_W'(w_u[FOLD_W-1:LIMB_W_EVEN]);
                    r_c        <= '0;
                    r_out_idx  <= '0;
                    r_state    <= EMIT;
                end
                EMIT: begin
                    if (!bus.m_valid) begin
                        bus.m_valid <= 1'b1;
                        bus.m_data  <= r_limbs[0];
                        bus.m_last  <= 1'b0;
                    end else if (bus.m_ready) begin
                        if (r_out_idx == 4'(NUM_LIMBS - 1)) begin
                            bus.m_valid <= 1'b0;
                            bus.m_last  <= 1'b0;
                            r_out_idx   <= '0;
                            bus.s_ready <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_out_idx  <= w_out_next;
                            bus.m_data <= r_limbs[w_out_next];
                            bus.m_last <= (r_out_idx == 4'(NUM_LIMBS - 2));
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIAT_25519_CARRY_CHAIN_ERR_EN
    // Sticky overflow flag, restarted by the first column of each frame
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err <= 1'b0;
        end else if (w_s_hs) begin
            if (r_state == IDLE) begin
                err <= w_ovf;
            end else begin
                err <= err | w_ovf;
            end
        end
    end
`endif

endmodule

// File: doc/fiat_25519_carry_square_carry_chain.md
FIAT_25519_CARRY_SQUARE_CARRY_CHAIN -- requirements
Module: fiat_25519_carry_square_carry_chain

Interface
REQ-001 SHALL have parameter ID, default 1, an instance tag only, with no functional effect.
REQ-002 SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port s_valid, input, 1 bit: column word valid.
REQ-005 SHALL have port s_ready, output, 1 bit: column word accepted when s_valid and s_ready are both high.
REQ-006 SHALL have port s_data, input, 64 bits: unsigned column sum of 32x32 partial products, column 0 first.
REQ-007 SHALL have port m_valid, output, 1 bit: reduced limb valid.
REQ-008 SHALL have port m_ready, input, 1 bit: limb consumed when m_valid and m_ready are both high.
REQ-009 SHALL have port m_data, output, 32 bits: reduced limb, zero-extended, limb 0 first.
REQ-010 SHALL have port m_last, output, 1 bit: high with limb 9.

Function
REQ-011 SHALL process frames of exactly 10 columns in and 10 limbs out; limb width w(i) = 26 for even i and 25 for odd i.
REQ-012 SHALL use an FSM with states IDLE, ACCUM, FOLD and EMIT; reset enters IDLE.
REQ-013 IDLE SHALL assert s_ready, clear the carry register c (39 bits) and clear the index counter.
- The first accepted word SHALL be handled as in ACCUM, and the FSM SHALL go to ACCUM.
REQ-014 ACCUM SHALL assert s_ready and, per accepted word i, compute t = s_data + c in 65 bits.
- SHALL store limb[i] = t mod 2^w(i) and set c = t >> w(i).
- Accepting column 9 SHALL move the FSM to FOLD.
REQ-015 FOLD SHALL last exactly one cycle with s_ready low, and SHALL compute u = limb[0] + 19*c (45 bits).
- SHALL set limb[0] = u mod 2^26 and limb[1] = limb[1] + (u >> 26), with no further carry.
- SHALL then go to EMIT.
REQ-016 EMIT SHALL hold m_valid high and present limb[k] on m_data; k advances only on a handshake.
- The handshake on limb 9 (m_last high) SHALL return the FSM to IDLE.
REQ-017 SHALL hold m_data and m_last stable while m_valid is high and m_ready is low.
REQ-018 SHALL keep s_ready low in FOLD and EMIT; a new frame is not accepted until EMIT completes.
REQ-019 Latency SHALL be 2 cycles from the column 9 handshake to the first m_valid (one cycle for FOLD, one to register).
- Throughput SHALL be one word per cycle in each direction when unstalled.
REQ-020 s_valid low in ACCUM SHALL insert bubbles without altering c or the index.
REQ-021 A 65-bit overflow of s_data + c SHALL be truncated to 64 bits before masking and shifting.

Reset
REQ-022 Asserting ap_rst_n low, including mid-frame, SHALL immediately set:
- s_ready = 0, m_valid = 0, m_data = 0, m_last = 0;
- c = 0, indices = 0, limb storage = 0, FSM = IDLE.
REQ-023 After deassertion, s_ready SHALL rise in the first clock cycle; no partial frame SHALL be emitted.

Configuration
REQ-024 Macro FIAT_25519_CARRY_CHAIN_ERR_EN, when defined, SHALL add port err, output, 1 bit.
- err is sticky, set when any ACCUM sum s_data + c exceeds 2^64-1.
- err clears on reset or at the first column handshake of the next frame.
REQ-025 Without FIAT_25519_CARRY_CHAIN_ERR_EN, SHALL have no err port and no overflow-detect logic; all other behaviour is identical.

Structure
REQ-026 A shared package fiat_25519_pkg SHALL hold:
- NUM_LIMBS = 10, LIMB_W_EVEN = 26, LIMB_W_ODD = 25, FOLD_K = 19;
- the FSM state enum type;
- the limb array typedef.
REQ-027 SHALL instantiate one sub-module, fiat_25519_carry_step: combinational add, mask and shift for one limb, parameterised by limb width.

Verification
REQ-028 All 10 columns = 0 -> limbs 0..9 all 0, m_last only on the 10th beat.
REQ-029 col0 = 2^26, others 0 -> limb0 = 0, limb1 = 1, rest 0.
REQ-030 col9 = 2^25, others 0 -> carry 1 folds: limb0 = 19, limb9 = 0, rest 0.
REQ-031 All columns = 2^64-1 with m_ready toggling every other cycle -> output equals the software model reduction, data held stable while stalled, err = 1 when FIAT_25519_CARRY_CHAIN_ERR_EN is defined.
REQ-032 ap_rst_n pulsed low after 5 columns, then a full frame with col0 = 7 -> single output frame, limb0 = 7, others 0.
REQ-033 s_valid low for 3 cycles between columns 4 and 5 -> result identical to the unstalled case, first m_valid 2 cycles after the column 9 handshake.
